// File: rtl/minimig_reset_pkg.sv
// minimig_reset_pkg: shared state encoding, cause codes and counter widths for the reset-request block
package minimig_reset_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_WAIT_SYS = 2'd3
  } state_e;
  typedef enum logic [1:0] {
    CAUSE_POR      = 2'd0,
    CAUSE_BOOTDONE = 2'd1,
    CAUSE_OSD      = 2'd2,
    CAUSE_KBD      = 2'd3
  } cause_e;
  localparam int HOLD_W = 8;
  localparam int DEB_W  = 4;
endpackage

// File: rtl/minimig_rst_debounce.sv
// minimig_rst_debounce: two-flop synchronizer plus saturating counter for the keyboard reset combo
module minimig_rst_debounce
  import minimig_reset_pkg::*;
#(
  parameter int KBD_DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk7_en,
  input  logic kbd_rst,
  output logic kbd_req
);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(KBD_DEBOUNCE);
  logic [1:0] sync_q, sync_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = clk7_en ? {sync_q[0], kbd_rst} : sync_q;
    cnt_d  = !clk7_en ? cnt_q : !sync_q[1] ? '0 : (cnt_q == DEB_MAX) ? cnt_q : cnt_q + DEB_W'(1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end
  assign kbd_req = (cnt_q == DEB_MAX);
endmodule

// File: rtl/minimig_reset_request.sv
// minimig_reset_request: collects bootdone/OSD/keyboard reset sources and pulses mrst to the reset generator.
// Define MINIMIG_KBD_DEBOUNCE_EN to synchronize and debounce kbd_rst; otherwise kbd_rst is used directly.
module minimig_reset_request
  import minimig_reset_pkg::*;
#(
  parameter int HOLD_TICKS   = 16,
  parameter int KBD_DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic       cia_both_sel,
  input  logic       osd_rst,
  input  logic       kbd_rst,
  input  logic       sys_reset,
  output logic       mrst,
  output logic       boot,
  output logic [1:0] rst_cause,
  output logic       busy
);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);
  state_e state_q, state_d;
  cause_e cause_q, cause_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic boot_q, boot_d, mrst_q, mrst_d, busy_q, busy_d;
  logic kbd_req, bootdone;
`ifdef MINIMIG_KBD_DEBOUNCE_EN
  minimig_rst_debounce #(.KBD_DEBOUNCE(KBD_DEBOUNCE)) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .kbd_rst (kbd_rst),
    .kbd_req (kbd_req)
  );
`else
  assign kbd_req = kbd_rst & (KBD_DEBOUNCE > 0);
`endif
  assign bootdone = cia_both_sel & boot_q & ~sys_reset;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hold_d  = hold_q;
    boot_d  = boot_q;
    mrst_d  = mrst_q;
    if (clk7_en) begin
      case (state_q)
        ST_IDLE: if (bootdone | osd_rst | kbd_req) begin
          state_d = ST_ASSERT;
          hold_d  = HOLD_LOAD;
          mrst_d  = 1'b1;
          cause_d = bootdone ? CAUSE_BOOTDONE : osd_rst ? CAUSE_OSD : CAUSE_KBD;
          boot_d  = boot_q & ~bootdone;
        end
        ST_ASSERT: if (hold_q == '0) begin
          state_d = ST_RELEASE;
          mrst_d  = 1'b0;
        end else hold_d = hold_q - HOLD_W'(1);
        ST_RELEASE: if (!osd_rst && !kbd_req) state_d = ST_WAIT_SYS;
        // bootdone is deliberately not a retrigger source here
        ST_WAIT_SYS: if (osd_rst | kbd_req) begin
          state_d = ST_ASSERT;
          hold_d  = HOLD_LOAD;
          mrst_d  = 1'b1;
          cause_d = osd_rst ? CAUSE_OSD : CAUSE_KBD;
        end else if (!sys_reset) state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT_SYS;
      cause_q <= CAUSE_POR;
      hold_q  <= '0;
      boot_q  <= 1'b1;
      mrst_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      hold_q  <= hold_d;
      boot_q  <= boot_d;
      mrst_q  <= mrst_d;
      busy_q  <= busy_d;
    end
  end
  assign mrst      = mrst_q;
  assign boot      = boot_q;
  assign rst_cause = cause_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_minimig_reset_request.sv
// tb_minimig_reset_request: directed stimulus with a spec-level model checked every cycle plus literal pins
module tb_minimig_reset_request;
  localparam int H = 16;
  localparam int D = 4;
  logic clk = 1'b0, reset_n, clk7_en, cia_both_sel, osd_rst, kbd_rst, sys_reset;
  logic mrst, boot, busy;
  logic [1:0] rst_cause;
  int passed = 0, total = 0;
  int hi, hi2;
  minimig_reset_request #(.HOLD_TICKS(H), .KBD_DEBOUNCE(D)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk7_en      (clk7_en),
    .cia_both_sel (cia_both_sel),
    .osd_rst      (osd_rst),
    .kbd_rst      (kbd_rst),
    .sys_reset    (sys_reset),
    .mrst         (mrst),
    .boot         (boot),
    .rst_cause    (rst_cause),
    .busy         (busy)
  );
  always #5 clk = ~clk;
  // model: idle / pulsing (m_left ticks of mrst remaining) / releasing / waiting for sys_reset
  bit m_idle, m_rel, m_wait, m_boot;
  int m_left, m_cause;
  logic [15:0] m_hist;
  always @(posedge clk or negedge reset_n) begin
    bit kq, bd;
    if (!reset_n) begin
      m_idle <= 0; m_rel <= 0; m_wait <= 1; m_boot <= 1;
      m_left <= 0; m_cause <= 0; m_hist <= '0;
    end else if (clk7_en) begin
`ifdef MINIMIG_KBD_DEBOUNCE_EN
      kq = &m_hist[D+1:2];
`else
      kq = kbd_rst;
`endif
      bd = m_idle && cia_both_sel && m_boot && !sys_reset;
      m_hist <= {m_hist[14:0], kbd_rst};
      if (m_idle) begin
        if (bd || osd_rst || kq) begin
          m_idle <= 0; m_left <= H;
          m_cause <= bd ? 1 : osd_rst ? 2 : 3;
          if (bd) m_boot <= 0;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        m_rel <= (m_left == 1);
      end else if (m_rel) begin
        if (!osd_rst && !kq) begin m_rel <= 0; m_wait <= 1; end
      end else if (m_wait) begin
        if (osd_rst || kq) begin m_wait <= 0; m_left <= H; m_cause <= osd_rst ? 2 : 3; end
        else if (!sys_reset) begin m_wait <= 0; m_idle <= 1; end
      end
    end
  end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) if (reset_n) begin
    check("model_mrst", int'(mrst), int'(m_left > 0));
    check("model_boot", int'(boot), int'(m_boot));
    check("model_cause", int'(rst_cause), m_cause);
    check("model_busy", int'(busy), int'(!m_idle));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mrst) h++;
    end
  endtask
  initial begin
    reset_n = 0; clk7_en = 1; cia_both_sel = 0; osd_rst = 0; kbd_rst = 0; sys_reset = 1;
    repeat (3) tick();
    check("rst_mrst", int'(mrst), 0);
    check("rst_boot", int'(boot), 1);
    check("rst_cause", int'(rst_cause), 0);
    check("rst_busy", int'(busy), 1);
    reset_n = 1;
    run(20, hi);
    check("por_busy", int'(busy), 1);
    check("por_no_mrst", hi, 0);
    sys_reset = 0;
    tick();
    check("por_idle", int'(busy), 0);
    check("por_boot", int'(boot), 1);
    check("por_cause", int'(rst_cause), 0);
    cia_both_sel = 1;
    run(1, hi);
    cia_both_sel = 0;
    check("bd_boot", int'(boot), 0);
    check("bd_cause", int'(rst_cause), 1);
    run(24, hi2);
    check("bd_pulse_len", hi + hi2, H);
    check("bd_idle", int'(busy), 0);
    cia_both_sel = 1;
    run(3, hi);
    cia_both_sel = 0;
    run(2, hi2);
    check("bd_ignored", hi + hi2, 0);
    kbd_rst = 1;
    run(3, hi);
    kbd_rst = 0;
    run(27, hi2);
`ifdef MINIMIG_KBD_DEBOUNCE_EN
    check("kbd_short", hi + hi2, 0);
`else
    check("kbd_short", hi + hi2, H);
`endif
    kbd_rst = 1;
    run(30, hi);
    check("kbd_pulse_len", hi, H);
    check("kbd_cause", int'(rst_cause), 3);
    check("kbd_release_busy", int'(busy), 1);
    run(10, hi);
    check("kbd_held_no_repulse", hi, 0);
    check("kbd_held_busy", int'(busy), 1);
    kbd_rst = 0;
    run(10, hi);
    check("kbd_done_idle", int'(busy), 0);
    kbd_rst = 1;
`ifdef MINIMIG_KBD_DEBOUNCE_EN
    repeat (D + 2) tick();
`endif
    osd_rst = 1;
    run(1, hi);
    osd_rst = 0; kbd_rst = 0;
    check("simul_cause", int'(rst_cause), 2);
    run(30, hi2);
    check("simul_pulse_len", hi + hi2, H);
    check("simul_idle", int'(busy), 0);
    kbd_rst = 1;
    run(8, hi);
    kbd_rst = 0; sys_reset = 1;
    clk7_en = 0;
    repeat (5) tick();
    check("freeze_mrst", int'(mrst), 1);
    clk7_en = 1;
    run(30, hi2);
    check("freeze_pulse_len", hi + hi2, H);
    check("wait_busy", int'(busy), 1);
    check("wait_cause", int'(rst_cause), 3);
    osd_rst = 1;
    run(1, hi);
    osd_rst = 0;
    run(25, hi2);
    check("retrig_pulse_len", hi + hi2, H);
    check("retrig_cause", int'(rst_cause), 2);
    check("retrig_busy", int'(busy), 1);
    sys_reset = 0;
    tick();
    check("retrig_idle", int'(busy), 0);
    reset_n = 0;
    #2 reset_n = 1;
    repeat (2) tick();
    cia_both_sel = 1;
    tick();
    cia_both_sel = 0;
    run(3, hi);
    check("mid_mrst_before", int'(mrst), 1);
    check("mid_boot_before", int'(boot), 0);
    #2 reset_n = 0;
    #1;
    check("mid_mrst", int'(mrst), 0);
    check("mid_boot", int'(boot), 1);
    check("mid_cause", int'(rst_cause), 0);
    check("mid_busy", int'(busy), 1);
    tick();
    reset_n = 1;
    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
